// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and
// baud-related constants.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   // 10 bit-times at 16x oversampling
   localparam int DEFAULT_TIMEOUT_TICKS = 160;
   localparam int OVERSAMPLE            = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request scanning upward from
// last+1, wrapping modulo NREQ. The previous owner is thus checked last.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NREQ = 3,
   localparam int IW  = $clog2(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [IW-1:0]   gnt_id,
   output logic            any
);

   // scan from farthest to nearest so the nearest candidate after last wins
   always_comb begin
      int idx;
      idx    = 0;
      gnt_id = '0;
      any    = |req;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NREQ;
         if (req[idx]) gnt_id = IW'(idx);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte-stream requesters. A grant is
// held for a whole packet; a stalled owner is dropped after TIMEOUT_TICKS
// baud sample ticks without a byte.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// SEND  | owner presents a byte; accept it and start the transmitter
// WAIT  | byte in flight; wait for tx_done
// HOLD  | mid-packet; owner owes its next byte, watchdog running
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ          = 3,
   parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
   parameter int TO_W          = 8,
   localparam int IW           = $clog2(NREQ)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic [IW-1:0]     grant_id,
   output logic              busy,
   output logic              timeout_pulse
);

   state_t          state;
   logic [IW-1:0]   last_grant;
   logic [IW-1:0]   pick_id;
   logic            pick_any;
   logic            last_q;
   logic [TO_W-1:0] to_cnt;
   logic            own_valid;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (req_valid),
      .last   (last_grant),
      .gnt_id (pick_id),
      .any    (pick_any)
   );

   assign own_valid = req_valid[grant_id];
   assign busy      = (state != IDLE);
   assign tx_start  = |req_ready;

   // accept strobe and byte mux; only the owner, only in SEND, only when it
   // actually presents a byte
   always_comb begin
      req_ready = '0;
      tx_data   = 8'h00;
      if (state == SEND) begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IW'(i)) begin
               tx_data      = req_data[8*i +: 8];
               req_ready[i] = req_valid[i];
            end
         end
      end
   end

   // arbitration FSM, packet-end tracking and stall watchdog
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         grant_id      <= '0;
         last_grant    <= IW'(NREQ - 1);
         last_q        <= 1'b0;
         to_cnt        <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_id <= pick_id;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (own_valid) begin
                  last_q <= req_last[grant_id];
                  state  <= WAIT;
               end else begin
                  // owner dropped valid at its grant; treat as a stall
                  to_cnt <= '0;
                  state  <= HOLD;
               end
            end
            WAIT: begin
               if (tx_done) begin
                  if (last_q) begin
                     last_grant <= grant_id;
                     state      <= IDLE;
                  end else begin
                     to_cnt <= '0;
                     state  <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (own_valid) begin
                  state <= SEND;
               end else if (tick) begin
                  if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                     timeout_pulse <= 1'b1;
                     last_grant    <= grant_id;
                     to_cnt        <= '0;
                     state         <= IDLE;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester byte queues, a fixed-latency
// transmitter model, and an expected-transfer queue checked on every tx_start.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NREQ     = 3;
   localparam int UART_LAT = 4;

   typedef struct packed {
      logic [2:0] id;
      logic [7:0] data;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          tick;
   logic [2:0]    req_valid;
   logic [23:0]   req_data;
   logic [2:0]    req_last;
   logic [2:0]    req_ready;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_done;
   logic [1:0]    grant_id;
   logic          busy;
   logic          timeout_pulse;

   uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_TICKS(160), .TO_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .tx_done       (tx_done),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   logic [8:0] rq [3][$];
   exp_t exp_q[$];
   logic [2:0] consumed = '0;
   int   done_cnt = 0;
   int   to_pulses = 0;
   int   cyc = 0;
   logic tick_en = 1'b0;
   logic cnt_armed = 1'b0;
   int   tick_cnt = 0;
   int   last_tick_cyc = 0;
   logic inject = 1'b0;
   logic injected = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, want);
      end
   endtask

   task automatic put(input int id, input logic [7:0] d, input logic l);
      rq[id].push_back({l, d});
   endtask

   task automatic expect_tx(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = 3'(id);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic upd();
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() > 0) begin
            req_valid[i]      = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]       = rq[i][0][8];
         end else begin
            req_valid[i]      = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]       = 1'b0;
         end
      end
   endtask

   // one clock: retire accepted bytes, run the transmitter model and tick source
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (consumed[i]) begin
            rq[i].delete(0);
            consumed[i] = 1'b0;
         end
      end
      if (tx_done) cnt_armed = 1'b1;
      tx_done = 1'b0;
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) tx_done = 1'b1;
      end
      cyc++;
      tick = tick_en && (cyc % 4 == 0);
      if (tick && cnt_armed) begin
         tick_cnt++;
         last_tick_cyc = cyc;
      end
      if (inject && tick && cnt_armed && tick_cnt == 160) begin
         put(2, 8'h67, 1'b1);
         expect_tx(2, 8'h67);
         inject   = 1'b0;
         injected = 1'b1;
      end
      upd();
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || busy || done_cnt > 0) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("wait_budget", n, 0);
   endtask

   // scoreboard monitor, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (timeout_pulse) to_pulses++;
         if (tx_start) begin
            if (exp_q.size() == 0) begin
               chk("sb_extra", tx_start, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_gid", grant_id, e.id);
               chk("sb_data", tx_data, e.data);
               chk("sb_ready", req_ready, 3'b001 << e.id);
            end
            for (int i = 0; i < NREQ; i++)
               if (req_ready[i]) consumed[i] = 1'b1;
            done_cnt = UART_LAT;
         end
      end
   end

   initial begin
      int n;
      int p0;
      reset = 1'b1; tick = 1'b0; tx_done = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;
      step(); step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_start", tx_start, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_to", timeout_pulse, 0);
      reset = 1'b0;
      step();

      // single one-byte packet, latency from valid to tx_start
      put(0, 8'h41, 1'b1);
      expect_tx(0, 8'h41);
      step();
      chk("t1_idle_ready", req_ready, 0);
      step();
      chk("t1_start", tx_start, 1);
      chk("t1_data", tx_data, 8'h41);
      chk("t1_ready", req_ready, 3'b001);
      wait_idle(200);
      chk("t1_busy", busy, 0);
      chk("t1_last_grant", dut.last_grant, 0);

      // three-byte packet from req1 holds off req0/req2
      put(1, 8'h10, 1'b0); put(1, 8'h11, 1'b0); put(1, 8'h12, 1'b1);
      put(0, 8'hA0, 1'b1); put(2, 8'hC0, 1'b1);
      expect_tx(1, 8'h10); expect_tx(1, 8'h11); expect_tx(1, 8'h12);
      expect_tx(2, 8'hC0); expect_tx(0, 8'hA0);
      wait_idle(300);

      // round robin with everyone continuously valid, last owner was 0
      put(0, 8'h01, 1'b1); put(0, 8'h04, 1'b1);
      put(1, 8'h02, 1'b1); put(1, 8'h05, 1'b1);
      put(2, 8'h03, 1'b1); put(2, 8'h06, 1'b1);
      expect_tx(1, 8'h02); expect_tx(2, 8'h03); expect_tx(0, 8'h01);
      expect_tx(1, 8'h05); expect_tx(2, 8'h06); expect_tx(0, 8'h04);
      wait_idle(300);

      // watchdog: req2 stalls after a non-last byte; req0 waits
      cnt_armed = 1'b0; tick_cnt = 0; tick_en = 1'b1;
      p0 = to_pulses;
      put(2, 8'h55, 1'b0); put(0, 8'h77, 1'b1);
      expect_tx(2, 8'h55); expect_tx(0, 8'h77);
      n = 0;
      while (!timeout_pulse && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) chk("to_seen", timeout_pulse, 1);
      chk("to_tick_cnt", tick_cnt, 160);
      chk("to_align", cyc - last_tick_cyc, 1);
      chk("to_busy", busy, 0);
      tick_en = 1'b0;
      step();
      chk("to_width", timeout_pulse, 0);
      chk("to_next_gid", grant_id, 0);
      wait_idle(200);
      chk("to_count", to_pulses - p0, 1);

      // valid returns on the very tick that would time out
      cnt_armed = 1'b0; tick_cnt = 0; tick_en = 1'b1; injected = 1'b0;
      p0 = to_pulses;
      put(2, 8'h66, 1'b0);
      expect_tx(2, 8'h66);
      inject = 1'b1;
      n = 0;
      while (!injected && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) chk("sim_injected", injected, 1);
      tick_en = 1'b0;
      step();
      chk("sim_send", tx_start, 1);
      chk("sim_no_to", timeout_pulse, 0);
      wait_idle(200);
      chk("sim_to_count", to_pulses - p0, 0);

      // reset while req1's byte is in flight
      put(1, 8'h31, 1'b0);
      expect_tx(1, 8'h31);
      n = 0;
      while (!tx_start && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("rw_start", tx_start, 1);
      step();
      chk("rw_in_wait", busy, 1);
      reset = 1'b1;
      step();
      done_cnt = 0;
      tx_done  = 1'b0;
      reset    = 1'b0;
      chk("rw_busy", busy, 0);
      chk("rw_start0", tx_start, 0);
      chk("rw_ready", req_ready, 0);
      chk("rw_data", tx_data, 0);
      chk("rw_gid", grant_id, 0);
      chk("rw_to", timeout_pulse, 0);
      put(0, 8'h0A, 1'b1); put(1, 8'h0B, 1'b1);
      expect_tx(0, 8'h0A); expect_tx(1, 8'h0B);
      wait_idle(300);
      chk("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
